cdc_handshake_tx: RTL
=====================

Name: cdc_handshake_tx

Overview:
- Source-domain end of a 4-phase req/ack bus handshake used to move multi-bit words (e.g. CSR/debug data) into another clock domain.
- Captures one word from a valid/ready producer and holds it stable on xfer_data while raising xfer_req.
- Synchronizes the returning xfer_ack_async internally through a flop chain, then completes the 4-phase return-to-zero sequence.
- Pairs with the destination-side flop synchronizer/receiver.

Parameters:
- DATA_WIDTH, 32, width of the transferred word.
- SYNC_STAGES, 2, flops in the internal ack synchronizer chain (legal values >= 2).
- TIMEOUT_CYCLES, 1023, cycles spent in REQ or RELEASE before timeout_err sets. 0 disables the timeout.

Ports:
- clk  input  1  source-domain clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_data  input  DATA_WIDTH  word to send.
- in_ready  output  1  block can accept a word this cycle.
- xfer_data  output  DATA_WIDTH  registered data, held stable for the whole handshake.
- xfer_req  output  1  registered request to the destination domain.
- xfer_ack_async  input  1  acknowledge from the destination domain, asynchronous to clk.
- done  output  1  one-cycle pulse when a handshake fully completes.
- busy  output  1  high whenever state != IDLE.
- timeout_err  output  1  sticky timeout flag.
- err_clr  input  1  clears timeout_err.

Behaviour:
- Reset (asynchronous, active-high; clock and reset are one clock, async active-high as decided):
  - state=IDLE.
  - xfer_req=0, xfer_data=0, done=0, timeout_err=0.
  - All ack synchronizer flops=0; timeout counter=0.
- ack_s: xfer_ack_async after SYNC_STAGES flops. An edge sampled at edge t is visible as ack_s after edge t+SYNC_STAGES-1.
- in_ready = (state==IDLE) && !ack_s. This is combinational from registers only; there is no in_valid-to-in_ready path.
- IDLE:
  - On in_valid && in_ready at a clock edge: xfer_data<=in_data, xfer_req<=1, state<=REQ.
  - xfer_req is high from the cycle after acceptance.
- REQ:
  - xfer_req held at 1.
  - When ack_s==1: xfer_req<=0, state<=RELEASE.
- RELEASE:
  - xfer_req held at 0.
  - When ack_s==0: state<=IDLE, done<=1 for exactly one cycle.
  - in_ready rises in the same cycle done is high.
- xfer_data must not change from the acceptance edge until state returns to IDLE. in_data and in_valid are ignored while busy.
- Stale ack: if ack_s==1 while in IDLE (destination still releasing, or a fault), in_ready stays low until ack_s==0. No request is issued against a high ack.
- Minimum round-trip, IDLE to done, with an instantly responding destination: 2*SYNC_STAGES+2 cycles.
- Timeout counter:
  - Cleared on entry to REQ and to RELEASE; increments each cycle in those states; saturates.
  - When the count equals TIMEOUT_CYCLES: timeout_err<=1.
  - State and xfer_req are NOT changed; no abort, because the protocol must not be broken.
- err_clr clears timeout_err on the next edge. If a set and err_clr coincide, set wins.
- Throughput: no back-to-back overlap; one word in flight at a time.
- Reset mid-handshake: xfer_req drops to 0 immediately (asynchronously) and xfer_data goes to 0. The destination must tolerate a request that drops early; no done is produced.
- Widths: timeout counter width = clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
- Basic transfer, SYNC_STAGES=2:
  - Stimulus: in_valid=1, in_data=0xDEADBEEF at edge 0; model the destination asserting xfer_ack_async 1 cycle after it sees xfer_req, and deasserting 1 cycle after req falls.
  - Required: xfer_req=1 from cycle 1; xfer_data=0xDEADBEEF throughout; done pulses exactly once at cycle 2*2+2 plus the model delays; in_ready=0 during busy.
- Data hold:
  - Stimulus: change in_data to 0x12345678 and keep in_valid=1 during the handshake.
  - Required: xfer_data stays 0xDEADBEEF; the second word is accepted only after done, then xfer_data=0x12345678.
- Stale ack:
  - Stimulus: hold xfer_ack_async=1 out of reset with in_valid=1.
  - Required: in_ready=0 and xfer_req=0 until ack has been low for 2 cycles; then acceptance.
- Timeout, TIMEOUT_CYCLES=8:
  - Stimulus: never assert ack.
  - Required: timeout_err=1 after 8 cycles in REQ; xfer_req stays 1. Then assert err_clr on the same cycle a second set occurs and check timeout_err stays 1. Then ack the transfer and check normal completion with done.
- Reset mid-op:
  - Stimulus: assert rst while in REQ.
  - Required: xfer_req=0 and xfer_data=0 immediately (asynchronously), busy=0, no done pulse; the next transfer works normally.
- Randomized destination ack delays of 0-20 cycles over 200 words:
  - Required: words received in order with no loss or duplication; done count equals 200.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a 4-phase req/ack handshake: captures one word, holds it on
// xfer_data while xfer_req is high, and synchronizes the returning ack internally.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] xfer_data,
  output logic                  xfer_req,
  input  logic                  xfer_ack_async,
  output logic                  done,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [DATA_WIDTH-1:0]  xfer_data_q, xfer_data_d;
  logic                   xfer_req_q, xfer_req_d;
  logic                   done_q, done_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_s;

  assign ack_s       = ack_sync_q[SYNC_STAGES-1];
  assign in_ready    = (state_q == ST_IDLE) && !ack_s;
  assign busy        = (state_q != ST_IDLE);
  assign xfer_data   = xfer_data_q;
  assign xfer_req    = xfer_req_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    ack_sync_d    = {ack_sync_q[SYNC_STAGES-2:0], xfer_ack_async};
    state_d       = state_q;
    xfer_data_d   = xfer_data_q;
    xfer_req_d    = xfer_req_q;
    done_d        = 1'b0;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    if (err_clr) timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        xfer_req_d = 1'b0;
        if (in_valid && in_ready) begin
          xfer_data_d = in_data;
          xfer_req_d  = 1'b1;
          state_d     = ST_REQ;
          cnt_d       = '0;
        end
      end
      ST_REQ: begin
        xfer_req_d = 1'b1;
        if (ack_s) begin
          xfer_req_d = 1'b0;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        xfer_req_d = 1'b0;
        if (!ack_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        xfer_req_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // Timeout only flags; the handshake itself is never aborted. Set beats err_clr.
    if (state_q != ST_IDLE) begin
      if (TIMEOUT_EN && (cnt_q == CNT_MAX)) timeout_err_d = 1'b1;
      if (state_d != state_q) cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ack_sync_q    <= '0;
      xfer_data_q   <= '0;
      xfer_req_q    <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ack_sync_q    <= ack_sync_d;
      xfer_data_q   <= xfer_data_d;
      xfer_req_q    <= xfer_req_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule
